// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS core HI/LO multiply/divide unit.
//   hilo_op_t    : operation code presented by decode with start_i
//   hilo_state_t : sequencer state of mips_cpu_hilo_ctrl
//   DIV_ITERS    : restoring-divide iterations (one per quotient bit)
//   MUL_LATENCY_MAX : largest legal multiply latency
package mips_cpu_pkg;

   localparam int unsigned DIV_ITERS       = 32;
   localparam int unsigned MUL_LATENCY_MAX = 8;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } hilo_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX
   } hilo_state_t;

endpackage

// File: rtl/mips_cpu_div_iter.sv
// Radix-2 restoring divider core, unsigned, one quotient bit per step.
//   clk, reset_n  : clock, synchronous active-low reset
//   load_i        : capture dividend/divisor, clear partial remainder
//   step_i        : perform one restoring iteration
//   dividend_i    : unsigned dividend
//   divisor_i     : unsigned divisor (caller guarantees non-zero)
//   quotient_o    : quotient, valid after DATA_W steps
//   remainder_o   : remainder, valid after DATA_W steps
module mips_cpu_div_iter #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o
);

   logic [DATA_W-1:0] r_q;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_div;
   logic [DATA_W:0]   w_shift;
   logic [DATA_W:0]   w_diff;

   // r_q starts as the dividend and is shifted out MSB-first while the
   // quotient bits are shifted in at the bottom.
   assign w_shift = {r_rem, r_q[DATA_W-1]};
   assign w_diff  = w_shift - {1'b0, r_div};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_q   <= '0;
         r_rem <= '0;
         r_div <= '0;
      end else if (load_i) begin
         r_q   <= dividend_i;
         r_rem <= '0;
         r_div <= divisor_i;
      end else if (step_i) begin
         if (!w_diff[DATA_W]) begin
            r_rem <= w_diff[DATA_W-1:0];
            r_q   <= {r_q[DATA_W-2:0], 1'b1};
         end else begin
            r_rem <= w_shift[DATA_W-1:0];
            r_q   <= {r_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign quotient_o  = r_q;
   assign remainder_o = r_rem;

endmodule

// File: rtl/mips_cpu_hilo_ctrl.sv
// HI/LO owner and multi-cycle multiply/divide sequencer for the MIPS core.
//   clk, reset_n : clock, synchronous active-low reset (aborts any op)
//   start_i/op_i : one-cycle op request, accepted only while idle
//   a_i, b_i     : rs/rt operands (dividend/multiplicand, divisor/multiplier)
//   rd_req_i     : decode holds MFHI/MFLO this cycle
//   busy_o       : operation in flight
//   done_o       : one-cycle pulse, HI/LO already updated
//   stall_o      : pipeline hold for HI/LO access or new op while busy
//   hi_o, lo_o   : architectural HI/LO registers
module mips_cpu_hilo_ctrl
   import mips_cpu_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 4,
   parameter int unsigned DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              rd_req_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              stall_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int unsigned CNT_W = 6;

   hilo_state_t         r_state, w_state_nxt;
   hilo_op_t            r_op, w_op;
   logic [DATA_W-1:0]   r_a, r_b, r_hi, r_lo;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_done;

   logic                w_accept, w_is_div_in, w_div_load;
   logic [DATA_W-1:0]   w_dvd, w_dvs;
   logic [2*DATA_W-1:0] w_ext_a, w_ext_b, w_prod;
   logic [DATA_W-1:0]   w_q, w_rem, w_q_fix, w_rem_fix;
   logic                w_neg_q, w_neg_r;

   assign w_op        = hilo_op_t'(op_i);
   assign w_accept    = start_i && (r_state == ST_IDLE);
   assign w_is_div_in = (w_op == OP_DIV) || (w_op == OP_DIVU);
   assign w_div_load  = w_accept && w_is_div_in && (b_i != '0);

   // Magnitudes for signed divide; 0x80000000 maps to itself, which is the
   // correct unsigned magnitude.
   assign w_dvd = ((w_op == OP_DIV) && a_i[DATA_W-1]) ? (DATA_W'(0) - a_i) : a_i;
   assign w_dvs = ((w_op == OP_DIV) && b_i[DATA_W-1]) ? (DATA_W'(0) - b_i) : b_i;

   mips_cpu_div_iter #(.DATA_W(DATA_W)) u_div (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_i      (w_div_load),
      .step_i      (r_state == ST_DIV),
      .dividend_i  (w_dvd),
      .divisor_i   (w_dvs),
      .quotient_o  (w_q),
      .remainder_o (w_rem)
   );

   // Low 2*DATA_W bits of the extended product are exact for both signed
   // and unsigned operands.
   assign w_ext_a = (r_op == OP_MULT) ? {{DATA_W{r_a[DATA_W-1]}}, r_a} : {{DATA_W{1'b0}}, r_a};
   assign w_ext_b = (r_op == OP_MULT) ? {{DATA_W{r_b[DATA_W-1]}}, r_b} : {{DATA_W{1'b0}}, r_b};
   assign w_prod  = w_ext_a * w_ext_b;

   assign w_neg_q   = (r_op == OP_DIV) && (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
   assign w_neg_r   = (r_op == OP_DIV) && r_a[DATA_W-1];
   assign w_q_fix   = w_neg_q ? (DATA_W'(0) - w_q)   : w_q;
   assign w_rem_fix = w_neg_r ? (DATA_W'(0) - w_rem) : w_rem;

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (w_op)
                  OP_MULT, OP_MULTU: w_state_nxt = ST_MUL;
                  OP_DIV, OP_DIVU:   w_state_nxt = (b_i == '0) ? ST_FIX : ST_DIV;
                  default:           w_state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_MUL:  if (r_cnt == '0) w_state_nxt = ST_IDLE;
         ST_DIV:  if (r_cnt == '0) w_state_nxt = ST_FIX;
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_op   <= OP_NOP;
         r_a    <= '0;
         r_b    <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_op <= w_op;
            r_a  <= a_i;
            r_b  <= b_i;
            case (w_op)
               OP_MTHI:           r_hi  <= a_i;
               OP_MTLO:           r_lo  <= a_i;
               OP_MULT, OP_MULTU: r_cnt <= CNT_W'(MUL_LATENCY - 1);
               OP_DIV, OP_DIVU:   r_cnt <= CNT_W'(DIV_ITERS - 1);
               default: ;
            endcase
         end
         case (r_state)
            ST_MUL: begin
               if (r_cnt == '0) begin
                  {r_hi, r_lo} <= w_prod;
                  r_done       <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DIV: begin
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            ST_FIX: begin
               // Zero divisor bypasses the divider entirely.
               if (r_b == '0) begin
                  r_hi <= r_a;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_q_fix;
               end
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy_o  = (r_state != ST_IDLE);
   assign done_o  = r_done;
   assign stall_o = busy_o && (rd_req_i || start_i);
   assign hi_o    = r_hi;
   assign lo_o    = r_lo;

endmodule
